cpu_control_fsm: RTL
====================

# cpu_control_fsm

Fetch/decode/execute sequencer for the 2-team 4-bit CPU. It fetches 16-bit instruction words from instruction memory over a req/ack handshake and splits each word into opcode, A and B fields. It drives the ALU with a start/done handshake, captures the result and advances the program counter. It sits between instruction memory and the ALU datapath and owns the PC.

## Interface
- `PC_W`, default 8: program counter / instruction address width (must be ≥ 1).
- `TIMEOUT`, default 15: maximum wait cycles on `mem_ack` / `alu_done`; used only with `CPU_CTRL_TIMEOUT_EN`.
- Reset: one clock; `rst` is synchronous and active-low.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous active-low reset.
- `start`  in  1  begin execution at PC 0; honoured only in IDLE or HALT.
- `mem_addr`  out  PC_W  instruction address; equals `pc`.
- `mem_req`  out  1  instruction read request.
- `mem_ack`  in  1  read complete; `mem_data` is valid in the same cycle.
- `mem_data`  in  16  instruction word: [15:12] opcode, [11:8] A, [7:4] B, [3:0] ignored.
- `alu_op`  out  4  latched opcode.
- `alu_a`  out  4  latched A field.
- `alu_b`  out  4  latched B field.
- `alu_start`  out  1  one-cycle ALU launch pulse.
- `alu_done`  in  1  ALU result valid.
- `alu_result`  in  8  ALU result.
- `result`  out  8  last captured ALU result.
- `result_valid`  out  1  one-cycle pulse when `result` updates.
- `pc`  out  PC_W  program counter.
- `busy`  out  1  high in every state except IDLE, HALT and FAULT.
- `halted`  out  1  high in HALT.
- `fault`  out  1  high in FAULT; tied 0 without the macro.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WAIT, WB, HALT, FAULT (FAULT exists only with the macro).
- All outputs are registered or decoded from the registered state. There is no combinational path from inputs to outputs.
- Reset (`rst`=0 at a rising edge) sets:
  - state to IDLE;
  - `pc`, instruction register, `alu_op`/`alu_a`/`alu_b`, `result` to 0;
  - every control output to 0.
- IDLE: when `start`=1, `pc`←0 and go to FETCH.
- FETCH: `mem_req`=1. On `mem_ack`=1, latch `mem_data` into the instruction register and go to DECODE. `mem_req` is low from the next cycle.
- `mem_ack` is ignored whenever `mem_req`=0.
- DECODE dispatches on the opcode:
  - 4'h0 NOP: `pc`←`pc`+1, go to FETCH.
  - 4'hE JMP: `pc`←{A,B} zero-extended to PC_W, or truncated to its low PC_W bits if PC_W<8; go to FETCH.
  - 4'hF HLT: go to HALT; `pc` unchanged.
  - Any other opcode: latch `alu_op`/`alu_a`/`alu_b`, go to EXEC.
- EXEC: `alu_start`=1 for this one cycle. If `alu_done`=1, go to WB; otherwise go to WAIT.
- WAIT: hold the ALU operands. On `alu_done`=1, go to WB.
- On the `alu_done` edge, `result`←`alu_result` and `pc`←`pc`+1.
- WB: `result_valid`=1 for one cycle, then go to FETCH.
- HALT: `halted`=1. `start`=1 sets `pc`←0 and goes to FETCH.
- PC increment wraps from 2^PC_W−1 to 0.
- `start` in any busy state is ignored.
- Reset mid-transaction drops `mem_req`/`alu_start` at once. An abandoned request is not replayed. A late `mem_ack`/`alu_done` arriving in IDLE is ignored.

## Timing
- Zero-latency memory and ALU (ack/done in the first asserted cycle):
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB);
  - NOP and JMP: 2 cycles;
  - HLT: 2 cycles to HALT.
- A memory ack N cycles after FETCH entry adds N cycles. An ALU done N cycles after EXEC adds N cycles.
- `alu_op`/`alu_a`/`alu_b` are stable from EXEC until the `alu_done` edge.
- `result` is valid in the WB cycle and holds until the next capture.

## Configuration
- `CPU_CTRL_TIMEOUT_EN` defined:
  - A wait counter clears on entering FETCH or EXEC.
  - It increments each cycle in FETCH without `mem_ack`, and each cycle in EXEC/WAIT without `alu_done`.
  - If the counter equals TIMEOUT and the awaited signal is still low, go to FAULT.
  - An ack/done arriving in the cycle where the counter equals TIMEOUT still wins.
  - FAULT: `fault`=1, all requests low. Exit only by `rst`; `start` is ignored.
- `CPU_CTRL_TIMEOUT_EN` undefined: waits indefinitely, no counter, no FAULT state, `fault`=0.

## Test plan
- Reset, then `start` with memory {0x1230 @0, 0xF000 @1}, immediate ack, ALU done immediately with 0x05:
  - `alu_op`=1, `alu_a`=2, `alu_b`=3, one `alu_start` pulse;
  - `result`=0x05 with `result_valid` 4 cycles after FETCH entry;
  - `halted`=1 with `pc`=1.
- JMP 0xE2A0 at PC 0 with PC_W=8 → next `mem_addr`=0x2A. With PC_W=4 → next `mem_addr`=0xA.
- `mem_ack` delayed 3 cycles and `alu_done` delayed 2 cycles:
  - `mem_req` high for exactly 4 cycles;
  - `alu_start` high for 1 cycle;
  - operands stable throughout.
- NOP at PC 0xFF (PC_W=8) → next fetch at 0x00.
- Assert `rst`=0 during WAIT → IDLE next cycle, all outputs 0. A later `alu_done` is ignored.
- With `CPU_CTRL_TIMEOUT_EN` and TIMEOUT=15, no `mem_ack` → `fault`=1 after the 16th FETCH cycle. With the macro undefined, the same stimulus stays in FETCH with `fault`=0.

Source files
------------

// File: rtl/cpu_control_fsm_if.sv
// Bus between the CPU control sequencer and its instruction memory / ALU environment.
// master = sequencer side, slave = memory/ALU side.
interface cpu_control_fsm_if #(
  parameter int PC_W = 8
) ();
  logic            start;
  logic [PC_W-1:0] mem_addr;
  logic            mem_req;
  logic            mem_ack;
  logic [15:0]     mem_data;
  logic [3:0]      alu_op;
  logic [3:0]      alu_a;
  logic [3:0]      alu_b;
  logic            alu_start;
  logic            alu_done;
  logic [7:0]      alu_result;
  logic [7:0]      result;
  logic            result_valid;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;
  logic            fault;

  modport master (
    input  start, mem_ack, mem_data, alu_done, alu_result,
    output mem_addr, mem_req, alu_op, alu_a, alu_b, alu_start,
           result, result_valid, pc, busy, halted, fault
  );

  modport slave (
    output start, mem_ack, mem_data, alu_done, alu_result,
    input  mem_addr, mem_req, alu_op, alu_a, alu_b, alu_start,
           result, result_valid, pc, busy, halted, fault
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Fetch/decode/execute sequencer for the 4-bit CPU; owns the PC, all outputs registered.
// Optional macro CPU_CTRL_TIMEOUT_EN adds a bounded wait on mem_ack/alu_done and a FAULT state.
module cpu_control_fsm #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  cpu_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
`ifdef CPU_CTRL_TIMEOUT_EN
    , S_FAULT = 3'd7
`endif
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [11:0]     r_ir;
  logic [3:0]      r_alu_op;
  logic [3:0]      r_alu_a;
  logic [3:0]      r_alu_b;
  logic [7:0]      r_result;
  logic            r_mem_req;
  logic            r_alu_start;
  logic            r_result_valid;
  logic            r_busy;
  logic            r_halted;
  logic            r_fault;

  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_jmp_target;
  logic            w_unused;

  assign w_pc_inc     = r_pc + PC_W'(1'b1);
  // {A,B} is zero-extended or truncated to the PC width.
  assign w_jmp_target = PC_W'(r_ir[7:0]);
  assign w_unused     = ^{bus.mem_data[3:0], TIMEOUT[0]};

`ifdef CPU_CTRL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_at_limit;
  assign w_at_limit = (r_wait_cnt == CNT_W'(TIMEOUT));
`endif

  // Sequencer: state, PC, instruction/operand latches and registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_pc           <= '0;
      r_ir           <= 12'h000;
      r_alu_op       <= 4'h0;
      r_alu_a        <= 4'h0;
      r_alu_b        <= 4'h0;
      r_result       <= 8'h00;
      r_mem_req      <= 1'b0;
      r_alu_start    <= 1'b0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_halted       <= 1'b0;
      r_fault        <= 1'b0;
`ifdef CPU_CTRL_TIMEOUT_EN
      r_wait_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            r_pc      <= '0;
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
            r_halted  <= 1'b0;
`ifdef CPU_CTRL_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end
        S_FETCH: begin
          if (bus.mem_ack) begin
            r_ir      <= bus.mem_data[15:4];
            r_state   <= S_DECODE;
            r_mem_req <= 1'b0;
          end
`ifdef CPU_CTRL_TIMEOUT_EN
          else if (w_at_limit) begin
            r_state   <= S_FAULT;
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
            r_fault   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1'b1);
          end
`endif
        end
        S_DECODE: begin
          case (r_ir[11:8])
            4'h0: begin
              r_pc      <= w_pc_inc;
              r_state   <= S_FETCH;
              r_mem_req <= 1'b1;
            end
            4'hE: begin
              r_pc      <= w_jmp_target;
              r_state   <= S_FETCH;
              r_mem_req <= 1'b1;
            end
            4'hF: begin
              r_state  <= S_HALT;
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
            end
            default: begin
              r_alu_op    <= r_ir[11:8];
              r_alu_a     <= r_ir[7:4];
              r_alu_b     <= r_ir[3:0];
              r_state     <= S_EXEC;
              r_alu_start <= 1'b1;
            end
          endcase
`ifdef CPU_CTRL_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        S_EXEC, S_WAIT: begin
          r_alu_start <= 1'b0;
          if (bus.alu_done) begin
            r_result       <= bus.alu_result;
            r_pc           <= w_pc_inc;
            r_state        <= S_WB;
            r_result_valid <= 1'b1;
          end
`ifdef CPU_CTRL_TIMEOUT_EN
          else if (w_at_limit) begin
            r_state <= S_FAULT;
            r_busy  <= 1'b0;
            r_fault <= 1'b1;
          end
`endif
          else begin
            r_state <= S_WAIT;
`ifdef CPU_CTRL_TIMEOUT_EN
            r_wait_cnt <= r_wait_cnt + CNT_W'(1'b1);
`endif
          end
        end
        S_WB: begin
          r_result_valid <= 1'b0;
          r_state        <= S_FETCH;
          r_mem_req      <= 1'b1;
`ifdef CPU_CTRL_TIMEOUT_EN
          r_wait_cnt     <= '0;
`endif
        end
`ifdef CPU_CTRL_TIMEOUT_EN
        // Only reset leaves FAULT.
        S_FAULT: begin
          r_mem_req   <= 1'b0;
          r_alu_start <= 1'b0;
          r_fault     <= 1'b1;
        end
`endif
        default: begin
          r_state        <= S_IDLE;
          r_mem_req      <= 1'b0;
          r_alu_start    <= 1'b0;
          r_result_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_halted       <= 1'b0;
          r_fault        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr     = r_pc;
  assign bus.pc           = r_pc;
  assign bus.mem_req      = r_mem_req;
  assign bus.alu_op       = r_alu_op;
  assign bus.alu_a        = r_alu_a;
  assign bus.alu_b        = r_alu_b;
  assign bus.alu_start    = r_alu_start;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.busy         = r_busy;
  assign bus.halted       = r_halted;
`ifdef CPU_CTRL_TIMEOUT_EN
  assign bus.fault        = r_fault;
`else
  assign bus.fault        = 1'b0 & r_fault;
`endif

endmodule
